// File: rtl/pulse_interval_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pulse_interval_checker
// Measures event-to-event spacing of a pulse stream; reports lock, early/late.
// Rev    : 1.0
// ============================================================================
module pulse_interval_checker #(
   parameter int INTERVAL = 3,
   parameter int TOL      = 0,
   parameter int LOCK_N   = 2,
   parameter int ERR_W    = 8,
   parameter int CW       = $clog2(INTERVAL + TOL + 2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             clear,
   output logic             locked,
   output logic             err_early,
   output logic             err_late,
   output logic [ERR_W-1:0] err_count,
   output logic [CW-1:0]    period_out,
   output logic             period_valid
);

   localparam int GW = $clog2(LOCK_N + 1);

   localparam logic [CW-1:0]    GAP_SAT  = CW'(INTERVAL + TOL + 1);
   localparam logic [CW-1:0]    GAP_LATE = CW'(INTERVAL + TOL);
   localparam logic [CW-1:0]    P_MIN    = CW'(INTERVAL - TOL);
   localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_N);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACQ    = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    gap_q, gap_d;
   logic [GW-1:0]    good_q, good_d, good_inc;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [CW-1:0]    period_out_q, period_out_d;
   logic             locked_q, locked_d;
   logic             err_early_q, err_early_d;
   logic             err_late_q, err_late_d;
   logic             period_valid_q, period_valid_d;
   logic             err_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         gap_q          <= '0;
         good_q         <= '0;
         err_count_q    <= '0;
         period_out_q   <= '0;
         locked_q       <= 1'b0;
         err_early_q    <= 1'b0;
         err_late_q     <= 1'b0;
         period_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         gap_q          <= gap_d;
         good_q         <= good_d;
         err_count_q    <= err_count_d;
         period_out_q   <= period_out_d;
         locked_q       <= locked_d;
         err_early_q    <= err_early_d;
         err_late_q     <= err_late_d;
         period_valid_q <= period_valid_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      gap_d          = gap_q;
      good_d         = good_q;
      good_inc       = good_q + GW'(1);
      err_count_d    = err_count_q;
      period_out_d   = period_out_q;
      err_early_d    = 1'b0;
      err_late_d     = 1'b0;
      period_valid_d = 1'b0;
      err_hit        = 1'b0;

      if (clear) begin
         // period_out deliberately keeps the last measurement across a clear
         state_d     = S_IDLE;
         gap_d       = '0;
         good_d      = '0;
         err_count_d = '0;
      end else begin
         if (pulse_in) begin
            gap_d = CW'(1);
         end else if (gap_q != GAP_SAT) begin
            gap_d = gap_q + CW'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (pulse_in) begin
                  state_d = S_ACQ;
                  good_d  = '0;
               end
            end
            S_ACQ, S_LOCKED: begin
               if (pulse_in) begin
                  period_out_d   = gap_q;
                  period_valid_d = 1'b1;
                  if (gap_q < P_MIN) begin
                     err_early_d = 1'b1;
                     err_hit     = 1'b1;
                     good_d      = '0;
                     state_d     = S_ACQ;
                  end else if (good_q != GOOD_MAX) begin
                     good_d = good_inc;
                     if (good_inc == GOOD_MAX) begin
                        state_d = S_LOCKED;
                     end
                  end
               end else if (gap_q == GAP_LATE) begin
                  // Reference is lost; the next pulse only re-seeds acquisition
                  err_late_d = 1'b1;
                  err_hit    = 1'b1;
                  good_d     = '0;
                  state_d    = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (err_hit && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
         end
      end

      locked_d = (state_d == S_LOCKED);
   end

   assign locked       = locked_q;
   assign err_early    = err_early_q;
   assign err_late     = err_late_q;
   assign err_count    = err_count_q;
   assign period_out   = period_out_q;
   assign period_valid = period_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_interval_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_pulse_interval_checker
// Three checker instances (base, TOL=1, ERR_W=2) against a timestamp model.
// Rev    : 1.0
// ============================================================================
module tb_pulse_interval_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [2:0] p;
   logic [2:0] c;
   logic [2:0] lk, ee, el, pv;
   logic [7:0] ec_a, ec_b;
   logic [1:0] ec_c;
   logic [2:0] po_a, po_b, po_c;

   int n_chk  = 0;
   int n_fail = 0;

   pulse_interval_checker #(.INTERVAL(3), .TOL(0), .LOCK_N(2), .ERR_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .pulse_in(p[0]), .clear(c[0]),
      .locked(lk[0]), .err_early(ee[0]), .err_late(el[0]),
      .err_count(ec_a), .period_out(po_a), .period_valid(pv[0]));

   pulse_interval_checker #(.INTERVAL(3), .TOL(1), .LOCK_N(2), .ERR_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .pulse_in(p[1]), .clear(c[1]),
      .locked(lk[1]), .err_early(ee[1]), .err_late(el[1]),
      .err_count(ec_b), .period_out(po_b), .period_valid(pv[1]));

   pulse_interval_checker #(.INTERVAL(3), .TOL(0), .LOCK_N(2), .ERR_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .pulse_in(p[2]), .clear(c[2]),
      .locked(lk[2]), .err_early(ee[2]), .err_late(el[2]),
      .err_count(ec_c), .period_out(po_c), .period_valid(pv[2]));

   // Model: remembers the time of the reference pulse and derives periods by subtraction
   typedef struct {
      bit has_ref;
      int ref_t;
      int good;
      bit locked;
      int errs;
      int period;
      bit pv;
      bit ee;
      bit el;
   } m_t;

   m_t m[3];
   int t;

   function automatic m_t m_reset();
      m_t s;
      s.has_ref = 0; s.ref_t = 0; s.good = 0; s.locked = 0;
      s.errs = 0; s.period = 0; s.pv = 0; s.ee = 0; s.el = 0;
      return s;
   endfunction

   function automatic m_t step(m_t s_in, bit pin, bit clr, int iv, int tol,
                               int lockn, int emax, int now);
      m_t s;
      int d;
      s = s_in;
      s.pv = 0; s.ee = 0; s.el = 0;
      if (clr) begin
         s.has_ref = 0; s.good = 0; s.errs = 0; s.locked = 0;
      end else if (!s.has_ref) begin
         if (pin) begin
            s.has_ref = 1; s.ref_t = now; s.good = 0;
         end
      end else begin
         d = now - s.ref_t;
         if (pin) begin
            s.period = d;
            s.pv     = 1;
            s.ref_t  = now;
            if (d < iv - tol) begin
               s.ee = 1; s.good = 0; s.locked = 0;
               s.errs = (s.errs < emax) ? s.errs + 1 : emax;
            end else begin
               s.good = (s.good < lockn) ? s.good + 1 : lockn;
               if (s.good == lockn) s.locked = 1;
            end
         end else if (d == iv + tol) begin
            s.el = 1; s.good = 0; s.locked = 0; s.has_ref = 0;
            s.errs = (s.errs < emax) ? s.errs + 1 : emax;
         end
      end
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t <= 0;
         for (int i = 0; i < 3; i++) m[i] <= m_reset();
      end else begin
         m[0] <= step(m[0], p[0], c[0], 3, 0, 2, 255, t);
         m[1] <= step(m[1], p[1], c[1], 3, 1, 2, 255, t);
         m[2] <= step(m[2], p[2], c[2], 3, 0, 2, 3, t);
         t    <= t + 1;
      end
   end

   function automatic int pk(logic l, logic e, logic la, logic v, int ec, int po);
      return (int'(l) << 15) | (int'(e) << 14) | (int'(la) << 13) | (int'(v) << 12)
           | ((ec & 255) << 4) | (po & 15);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_a", pk(lk[0], ee[0], el[0], pv[0], int'(ec_a), int'(po_a)),
          pk(m[0].locked, m[0].ee, m[0].el, m[0].pv, m[0].errs, m[0].period));
      chk("cyc_b", pk(lk[1], ee[1], el[1], pv[1], int'(ec_b), int'(po_b)),
          pk(m[1].locked, m[1].ee, m[1].el, m[1].pv, m[1].errs, m[1].period));
      chk("cyc_c", pk(lk[2], ee[2], el[2], pv[2], int'(ec_c), int'(po_c)),
          pk(m[2].locked, m[2].ee, m[2].el, m[2].pv, m[2].errs, m[2].period));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One character per cycle: '1' pulse, 'C' clear together with a pulse, else idle
   task automatic drive(input int inst, input string pat);
      for (int i = 0; i < pat.len(); i++) begin
         p[inst] = (pat[i] == "1") || (pat[i] == "C");
         c[inst] = (pat[i] == "C");
         tick();
      end
      p[inst] = 1'b0;
      c[inst] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      p     = '0;
      c     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_a", pk(lk[0], ee[0], el[0], pv[0], int'(ec_a), int'(po_a)), 0);
      chk("reset_c", pk(lk[2], ee[2], el[2], pv[2], int'(ec_c), int'(po_c)), 0);
      rst_n = 1'b1;
      tick();

      // Lock on a clean period-3 stream
      drive(0, "1001001001");
      chk("lock_pv", int'(pv[0]), 1);
      chk("lock_period", int'(po_a), 3);
      chk("lock_locked", int'(lk[0]), 1);
      chk("lock_errs", int'(ec_a), 0);

      // Extra pulse one cycle after the last
      drive(0, "1");
      chk("early_strobe", int'(ee[0]), 1);
      chk("early_period", int'(po_a), 1);
      chk("early_errs", int'(ec_a), 1);
      chk("early_unlock", int'(lk[0]), 0);
      drive(0, "001001");
      chk("relock", int'(lk[0]), 1);

      // Silence after the reference
      drive(0, "000");
      chk("late_strobe", int'(el[0]), 1);
      chk("late_unlock", int'(lk[0]), 0);
      chk("late_errs", int'(ec_a), 2);
      drive(0, "00000");
      chk("silent_no_err", pk(lk[0], ee[0], el[0], pv[0], int'(ec_a), 0), pk(0, 0, 0, 0, 2, 0));

      // Continuous high: early every cycle after the first
      drive(0, "1111");
      chk("held_high_errs", int'(ec_a), 5);
      drive(0, "001001");
      chk("pre_reset_lock", int'(lk[0]), 1);

      // Asynchronous reset between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_a", pk(lk[0], ee[0], el[0], pv[0], int'(ec_a), int'(po_a)), 0);
      #49;
      rst_n = 1'b1;
      tick();
      drive(0, "1");
      chk("post_rst_first_pv", int'(pv[0]), 0);
      drive(0, "001");
      chk("post_rst_one_interval", pk(lk[0], 0, 0, pv[0], 0, int'(po_a)), pk(0, 0, 0, 1, 0, 3));
      drive(0, "001");
      chk("post_rst_relock", int'(lk[0]), 1);

      // TOL=1: periods 2,3,4 accepted, gap 4 with no pulse is late, period 1 early
      drive(1, "1010010001");
      chk("tol_period4", int'(po_b), 4);
      chk("tol_locked", int'(lk[1]), 1);
      chk("tol_errs", int'(ec_b), 0);
      drive(1, "0000");
      chk("tol_late", pk(lk[1], ee[1], el[1], 0, int'(ec_b), 0), pk(0, 0, 1, 0, 1, 0));
      drive(1, "11");
      chk("tol_early", pk(0, ee[1], el[1], 0, int'(ec_b), int'(po_b)), pk(0, 1, 0, 0, 2, 1));

      // ERR_W=2: saturation, then clear coinciding with a pulse
      drive(2, "111111");
      chk("sat_errs", int'(ec_c), 3);
      drive(2, "C");
      chk("clear_outputs", pk(lk[2], ee[2], el[2], pv[2], int'(ec_c), int'(po_c)),
          pk(0, 0, 0, 0, 0, 1));
      drive(2, "001");
      chk("clear_pulse_ignored", int'(pv[2]), 0);
      drive(2, "001");
      chk("after_clear_period", pk(0, 0, 0, pv[2], int'(ec_c), int'(po_c)), pk(0, 0, 0, 1, 0, 3));

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
